// File: rtl/f15_rise_decay_sched_if.sv
// Beat stream, bin-memory and rise/decay-unit signals of the fosphor line scheduler.
// The slave side is the scheduler; the master side is the beat source plus memory/unit.
interface f15_rise_decay_sched_if #(
    parameter int AW = 10
);
    logic          in_valid;
    logic          in_ready;
    logic [AW-1:0] in_addr;
    logic          in_hit;
    logic          in_last;

    logic          rd_en;
    logic [AW-1:0] rd_addr;

    logic [15:0]   dp_k;
    logic          dp_ena;
    logic          dp_mode;

    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic          wr_zero;

    modport master (
        output in_valid, in_addr, in_hit, in_last,
        input  in_ready,
        input  rd_en, rd_addr,
        input  dp_k, dp_ena, dp_mode,
        input  wr_en, wr_addr, wr_zero
    );

    modport slave (
        input  in_valid, in_addr, in_hit, in_last,
        output in_ready,
        output rd_en, rd_addr,
        output dp_k, dp_ena, dp_mode,
        output wr_en, wr_addr, wr_zero
    );
endinterface

// File: rtl/f15_rise_decay_sched.sv
// Line scheduler for the fosphor rise/decay unit: issues bin reads, aligned unit controls
// and write-backs, applies decay every N lines and runs whole-memory clear sweeps.
module f15_rise_decay_sched #(
    parameter int AW     = 10,
    parameter int RD_LAT = 2,
    parameter int DP_LAT = 5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] cfg_k_rise,
    input  logic [15:0] cfg_k_decay,
    input  logic        cfg_rise_ena,
    input  logic        cfg_decay_ena,
    input  logic [7:0]  cfg_decay_div,
    input  logic        cfg_clear,
    output logic        clear_busy,
    f15_rise_decay_sched_if.slave bus
);
    localparam int W  = RD_LAT + DP_LAT;
    localparam int DW = $clog2(W + 1);

    localparam logic [1:0] ST_RUN   = 2'd0;
    localparam logic [1:0] ST_DRAIN = 2'd1;
    localparam logic [1:0] ST_CLEAR = 2'd2;

    typedef struct packed {
        logic [15:0] k_rise;
        logic [15:0] k_decay;
        logic        rise_ena;
        logic        decay_ena;
        logic [7:0]  div;
    } cfg_t;

    // One slot per cycle of read + unit latency; slot 0 drives the read port.
    typedef struct packed {
        logic          v;
        logic [AW-1:0] addr;
        logic [15:0]   k;
        logic          ena;
        logic          mode;
        logic          zero;
    } slot_t;

    logic [1:0]    state_q, state_d;
    logic [DW-1:0] drain_q, drain_d;
    logic [AW-1:0] sweep_q, sweep_d;
    logic          pending_q, pending_d;
    logic          after_clr_q, after_clr_d;
    logic          line_active_q, line_active_d;
    logic [7:0]    line_cnt_q, line_cnt_d;
    cfg_t          cfg_q, cfg_d;
    slot_t         pipe_q [0:W];
    slot_t         pipe_d [0:W];

    cfg_t cfg_live;
    cfg_t cfg_eff;
    logic accept;
    logic clr_req;

    assign cfg_live = {cfg_k_rise, cfg_k_decay, cfg_rise_ena, cfg_decay_ena, cfg_decay_div};

    // The first beat of a line uses live config; later beats use the copy taken then.
    assign cfg_eff = line_active_q ? cfg_q : cfg_live;

    assign bus.in_ready = (state_q == ST_RUN);
    assign accept       = bus.in_valid & bus.in_ready;
    assign clear_busy   = pending_q | (state_q == ST_CLEAR) | ((state_q == ST_DRAIN) & after_clr_q);
    assign clr_req      = pending_q | (cfg_clear & ~clear_busy);

    always_comb begin
        // NOTE: every signal gets its default first, so no path through the block leaves it unassigned and infers a latch.
        state_d       = state_q;
        drain_d       = drain_q;
        sweep_d       = sweep_q;
        pending_d     = pending_q;
        after_clr_d   = after_clr_q;
        line_active_d = line_active_q;
        line_cnt_d    = line_cnt_q;
        cfg_d         = cfg_q;

        if (cfg_clear && !clear_busy) begin
            pending_d = 1'b1;
        end

        if (accept) begin
            if (!line_active_q) begin
                cfg_d = cfg_live;
            end
            line_active_d = ~bus.in_last;
            if (bus.in_last) begin
                line_cnt_d = (line_cnt_q == 8'd0) ? cfg_eff.div : line_cnt_q - 8'd1;
            end
        end

        case (state_q)
            ST_RUN: begin
                if (accept && bus.in_last) begin
                    state_d = ST_DRAIN;
                    drain_d = DW'(W);
                end else if (!accept && !line_active_q && clr_req) begin
                    state_d   = ST_CLEAR;
                    sweep_d   = '0;
                    pending_d = 1'b0;
                end
            end
            ST_DRAIN: begin
                if (drain_q == '0) begin
                    after_clr_d = 1'b0;
                    if (clr_req) begin
                        state_d   = ST_CLEAR;
                        sweep_d   = '0;
                        pending_d = 1'b0;
                    end else begin
                        state_d = ST_RUN;
                    end
                end else begin
                    drain_d = drain_q - DW'(1);
                end
            end
            ST_CLEAR: begin
                line_cnt_d = 8'd0;
                sweep_d    = sweep_q + AW'(1);
                if (sweep_q == '1) begin
                    state_d     = ST_DRAIN;
                    drain_d     = DW'(W);
                    after_clr_d = 1'b1;
                end
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase
    end

    always_comb begin
        pipe_d[0] = '0;
        if (accept) begin
            pipe_d[0].v    = 1'b1;
            pipe_d[0].addr = bus.in_addr;
            if (bus.in_hit) begin
                pipe_d[0].k    = cfg_eff.k_rise;
                pipe_d[0].ena  = cfg_eff.rise_ena;
                pipe_d[0].mode = 1'b0;
            end else begin
                pipe_d[0].k    = cfg_eff.k_decay;
                pipe_d[0].ena  = cfg_eff.decay_ena & (line_cnt_q == 8'd0);
                pipe_d[0].mode = 1'b1;
            end
        end else if (state_q == ST_CLEAR) begin
            pipe_d[0].v    = 1'b1;
            pipe_d[0].addr = sweep_q;
            pipe_d[0].zero = 1'b1;
        end
        for (int i = 1; i <= W; i++) begin
            pipe_d[i] = pipe_q[i-1];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: state updates use non-blocking assignments so every flop samples pre-edge values regardless of statement order.
            state_q       <= ST_RUN;
            drain_q       <= '0;
            sweep_q       <= '0;
            pending_q     <= 1'b0;
            after_clr_q   <= 1'b0;
            line_active_q <= 1'b0;
            line_cnt_q    <= 8'd0;
            cfg_q         <= '0;
            // NOTE: the slot pipeline is small flop storage, not RAM, and is cleared so in-flight reads/writes never survive reset.
            for (int i = 0; i <= W; i++) begin
                pipe_q[i] <= '0;
            end
        end else begin
            state_q       <= state_d;
            drain_q       <= drain_d;
            sweep_q       <= sweep_d;
            pending_q     <= pending_d;
            after_clr_q   <= after_clr_d;
            line_active_q <= line_active_d;
            line_cnt_q    <= line_cnt_d;
            cfg_q         <= cfg_d;
            pipe_q        <= pipe_d;
        end
    end

    // Empty slots carry all-zero fields, so controls read 0 on cycles with no beat.
    assign bus.rd_en   = pipe_q[0].v;
    assign bus.rd_addr = pipe_q[0].addr;
    assign bus.dp_k    = pipe_q[RD_LAT].k;
    assign bus.dp_ena  = pipe_q[RD_LAT].ena;
    assign bus.dp_mode = pipe_q[RD_LAT].mode;
    assign bus.wr_en   = pipe_q[W].v;
    assign bus.wr_addr = pipe_q[W].addr;
    assign bus.wr_zero = pipe_q[W].zero;
endmodule

// File: tb/tb_f15_rise_decay_sched.sv
// Randomized bench for the line scheduler: a cycle-indexed scoreboard of expected
// read/control/write events built from the line, decay-divider and clear rules.
module tb_f15_rise_decay_sched;
    localparam int AW     = 4;
    localparam int RD_LAT = 2;
    localparam int DP_LAT = 5;
    localparam int W      = RD_LAT + DP_LAT;
    localparam int NBINS  = 1 << AW;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] cfg_k_rise    = '0;
    logic [15:0] cfg_k_decay   = '0;
    logic        cfg_rise_ena  = 1'b0;
    logic        cfg_decay_ena = 1'b0;
    logic [7:0]  cfg_decay_div = '0;
    logic        cfg_clear     = 1'b0;
    logic        clear_busy;

    f15_rise_decay_sched_if #(.AW(AW)) bus ();

    f15_rise_decay_sched #(.AW(AW), .RD_LAT(RD_LAT), .DP_LAT(DP_LAT)) dut (
        .clk           (clk),
        .rst           (rst),
        .cfg_k_rise    (cfg_k_rise),
        .cfg_k_decay   (cfg_k_decay),
        .cfg_rise_ena  (cfg_rise_ena),
        .cfg_decay_ena (cfg_decay_ena),
        .cfg_decay_div (cfg_decay_div),
        .cfg_clear     (cfg_clear),
        .clear_busy    (clear_busy),
        .bus           (bus)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [15:0] k;
        logic        ena;
        logic        mode;
    } dp_t;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: expected events keyed by the cycle they must appear on.
    logic [AW-1:0] exp_rd [int];
    dp_t           exp_dp [int];
    logic [AW:0]   exp_wr [int];
    int   cyc = 0;
    bit   model_valid = 0;
    bit   m_acc = 0;
    int   ready_from = 0;
    int   clear_done = 0;
    bit   pending = 0;
    bit   line_open = 0;
    int   line_cnt = 0;
    logic [15:0] snap_kr, snap_kd;
    logic        snap_re, snap_de, snap_decay_line;
    logic [7:0]  snap_div;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s cyc=%0d got=%h want=%h", tag, cyc, obs, exp);
        end
    endtask

    task automatic schedule(input int t, input logic [AW-1:0] addr, input dp_t dp, input logic zero);
        exp_rd[t+1]          = addr;
        exp_dp[t+1+RD_LAT]   = dp;
        exp_wr[t+1+W]        = {addr, zero};
    endtask

    task automatic model_eval();
        bit ready, busy, req;
        logic [31:0] obs, exp;
        dp_t dp;
        int s;
        ready = (cyc >= ready_from);
        busy  = pending || (cyc < clear_done);
        if (model_valid) begin
            obs = 32'({bus.rd_en, bus.rd_addr});
            exp = exp_rd.exists(cyc) ? 32'({1'b1, exp_rd[cyc]}) : 32'd0;
            check("rd", obs, exp);
            obs = 32'({bus.dp_k, bus.dp_ena, bus.dp_mode});
            exp = exp_dp.exists(cyc) ? 32'(exp_dp[cyc]) : 32'd0;
            check("dp", obs, exp);
            obs = 32'({bus.wr_en, bus.wr_addr, bus.wr_zero});
            exp = exp_wr.exists(cyc) ? 32'({1'b1, exp_wr[cyc]}) : 32'd0;
            check("wr", obs, exp);
            check("rdy", 32'(bus.in_ready), 32'(ready));
            check("busy", 32'(clear_busy), 32'(busy));
        end
        exp_rd.delete(cyc);
        exp_dp.delete(cyc);
        exp_wr.delete(cyc);
        m_acc = 0;
        if (rst) begin
            exp_rd.delete();
            exp_dp.delete();
            exp_wr.delete();
            ready_from  = 0;
            clear_done  = 0;
            pending     = 0;
            line_open   = 0;
            line_cnt    = 0;
            model_valid = 1;
            cyc++;
            return;
        end
        m_acc = bus.in_valid && ready;
        req   = pending || (cfg_clear && !busy);
        if (cfg_clear && !busy) pending = 1;
        if (m_acc) begin
            if (!line_open) begin
                snap_kr = cfg_k_rise;
                snap_kd = cfg_k_decay;
                snap_re = cfg_rise_ena;
                snap_de = cfg_decay_ena;
                snap_div = cfg_decay_div;
                snap_decay_line = (line_cnt == 0);
                line_open = 1;
            end
            if (bus.in_hit) dp = '{k: snap_kr, ena: snap_re, mode: 1'b0};
            else            dp = '{k: snap_kd, ena: snap_de & snap_decay_line, mode: 1'b1};
            schedule(cyc, bus.in_addr, dp, 1'b0);
            if (bus.in_last) begin
                line_cnt   = (line_cnt == 0) ? int'(snap_div) : line_cnt - 1;
                line_open  = 0;
                ready_from = cyc + 2 + W;
            end
        end else if (req && !line_open && cyc + 1 >= ready_from) begin
            pending = 0;
            s = cyc + 1;
            for (int i = 0; i < NBINS; i++) schedule(s + i, AW'(i), '0, 1'b1);
            line_cnt   = 0;
            ready_from = s + NBINS + 1 + W;
            clear_done = ready_from;
        end
        cyc++;
    endtask

    task automatic step();
        @(negedge clk);
        model_eval();
        @(posedge clk);
        #1;
    endtask

    task automatic set_cfg(input logic [15:0] kr, input logic [15:0] kd, input logic re,
                           input logic de, input logic [7:0] div);
        cfg_k_rise = kr; cfg_k_decay = kd; cfg_rise_ena = re; cfg_decay_ena = de; cfg_decay_div = div;
    endtask

    task automatic randomize_cfg();
        set_cfg(16'($urandom), 16'($urandom), $urandom_range(0, 3) != 0,
                $urandom_range(0, 3) != 0, 8'($urandom_range(0, 3)));
    endtask

    task automatic pulse_reset();
        bus.in_valid = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    // Send one line; optionally pulse cfg_clear on beat clear_at or reset before beat rst_at.
    task automatic send_line(input int n, input logic [15:0] hits, input int base, input int stride,
                             input bit rnd, input int clear_at, input int rst_at);
        int waited;
        for (int b = 0; b < n; b++) begin
            if (rnd) begin
                repeat ($urandom_range(0, 2)) begin
                    if ($urandom_range(0, 2) == 0) randomize_cfg();
                    cfg_clear = ($urandom_range(0, 80) == 0);
                    step();
                    cfg_clear = 1'b0;
                end
            end
            if (b == rst_at) begin
                pulse_reset();
                return;
            end
            bus.in_valid = 1'b1;
            bus.in_addr  = AW'(base + b * stride);
            bus.in_hit   = hits[b];
            bus.in_last  = (b == n - 1);
            cfg_clear    = (b == clear_at);
            waited = 0;
            do begin
                if (rnd && $urandom_range(0, 3) == 0) randomize_cfg();
                step();
                cfg_clear = 1'b0;
                waited++;
            end while (!m_acc && waited < 400);
            if (!m_acc) check("accept_wait", 32'(m_acc), 32'd1);
        end
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
    endtask

    task automatic wait_idle();
        int waited;
        waited = 0;
        while ((cyc < ready_from || cyc < clear_done || pending || exp_wr.size() != 0) && waited < 2000) begin
            step();
            waited++;
        end
        step();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog cyc=%0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        bus.in_valid = 1'b0;
        bus.in_addr  = '0;
        bus.in_hit   = 1'b0;
        bus.in_last  = 1'b0;
        repeat (3) step();
        rst = 1'b0;
        step();

        // 4-beat line, hits on beats 0 and 2, every line decays.
        set_cfg(16'h1000, 16'h0100, 1'b1, 1'b1, 8'd0);
        send_line(4, 16'h0005, 0, 1, 0, -1, -1);
        wait_idle();

        // Decay every third line over six all-miss lines.
        set_cfg(16'h1000, 16'h0100, 1'b1, 1'b1, 8'd2);
        for (int l = 0; l < 6; l++) send_line(3, 16'h0000, l, 3, 0, -1, -1);
        wait_idle();

        // Rise disabled: hits carry ena=0.
        set_cfg(16'h2222, 16'h0333, 1'b0, 1'b1, 8'd0);
        send_line(5, 16'h001f, 7, 5, 0, -1, -1);
        wait_idle();

        // Clear requested mid-line: line completes, then a full sweep.
        set_cfg(16'h1234, 16'h0042, 1'b1, 1'b1, 8'd1);
        send_line(6, 16'h0029, 3, 5, 0, 2, -1);
        wait_idle();

        // Clear from idle, and clear coincident with a first beat.
        cfg_clear = 1'b1;
        step();
        cfg_clear = 1'b0;
        wait_idle();
        send_line(3, 16'h0002, 9, 7, 0, 0, -1);
        wait_idle();

        // Reset three beats into a line, then three cycles into a sweep.
        send_line(8, 16'h00a5, 1, 3, 0, -1, 3);
        repeat (3) step();
        cfg_clear = 1'b1;
        step();
        cfg_clear = 1'b0;
        repeat (3) step();
        pulse_reset();
        repeat (3) step();

        // Random lines with config churn mid-line and occasional clears.
        for (int l = 0; l < 60; l++) begin
            send_line($urandom_range(1, NBINS), 16'($urandom), $urandom_range(0, NBINS - 1),
                      2 * $urandom_range(0, 7) + 1, 1,
                      ($urandom_range(0, 9) == 0) ? $urandom_range(0, 3) : -1, -1);
        end
        wait_idle();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
